// File: rtl/rc_add_sub_serial.sv
// Digit-serial ripple-carry add/subtract: one DIGIT-wide slice is reused over N cycles,
// with a start/busy/done handshake and carry, signed-overflow and zero flags.
//
// state  | meaning
// S_IDLE | waiting for START
// S_RUN  | one digit slice per clock, LSB digit first
// S_DONE | single-cycle result-valid pulse; may accept the next START
module rc_add_sub_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SnA,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] Y,
   output logic             CO,
   output logic             OV,
   output logic             ZERO
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
         $error("rc_add_sub_serial: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, bx_q, acc_q, acc_d;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
   logic             cout, ov_dig, last, accept;

   assign last   = (cnt_q == CW'(N - 1));
   assign accept = (state_q != S_RUN) && START;
   assign BUSY   = (state_q == S_RUN);
   assign DONE   = (state_q == S_DONE);

   always_comb begin
      a_dig             = a_q[int'(cnt_q) * DIGIT +: DIGIT];
      b_dig             = bx_q[int'(cnt_q) * DIGIT +: DIGIT];
      {cout, sum_dig}   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
      // Operands share a sign but the sum does not: equals carry-in(MSB) ^ carry-out(MSB).
      ov_dig            = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (sum_dig[DIGIT-1] != a_dig[DIGIT-1]);
      acc_d             = acc_q;
      acc_d[int'(cnt_q) * DIGIT +: DIGIT] = sum_dig;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_RUN;
         S_RUN:   if (last) state_d = S_DONE;
         S_DONE:  state_d = START ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         a_q     <= '0;
         bx_q    <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         Y       <= '0;
         CO      <= 1'b0;
         OV      <= 1'b0;
         ZERO    <= 1'b0;
      end else if (accept) begin
         a_q     <= A;
         bx_q    <= SnA ? ~B : B;
         carry_q <= SnA;
         cnt_q   <= '0;
      end else if (state_q == S_RUN) begin
         acc_q   <= acc_d;
         carry_q <= cout;
         // Wrap on the last digit so the slice index never leaves the operand range.
         cnt_q   <= last ? '0 : cnt_q + CW'(1);
         if (last) begin
            Y    <= acc_d;
            CO   <= cout;
            OV   <= ov_dig;
            ZERO <= (acc_d == '0);
         end
      end
   end

endmodule

// File: tb/tb_rc_add_sub_serial.sv
// Self-checking bench for rc_add_sub_serial: directed vector table, handshake corner
// sequences, random operands against an arithmetic reference, and two parameter variants.
module tb_rc_add_sub_serial;

   logic        clk, rst;
   logic        start, sna, busy, done, co, ov, zero;
   logic [31:0] a, b, y;
   logic        start64, sna64, busy64, done64, co64, ov64, zero64;
   logic [63:0] a64, b64, y64;
   logic        start1, sna1, busy1, done1, co1, ov1, zero1;
   logic [31:0] a1, b1, y1;

   int checks = 0;
   int errors = 0;

   rc_add_sub_serial #(.WIDTH(32), .DIGIT(8)) dut (
      .CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .SnA(sna),
      .BUSY(busy), .DONE(done), .Y(y), .CO(co), .OV(ov), .ZERO(zero));

   rc_add_sub_serial #(.WIDTH(64), .DIGIT(16)) dut64 (
      .CLK(clk), .RST(rst), .START(start64), .A(a64), .B(b64), .SnA(sna64),
      .BUSY(busy64), .DONE(done64), .Y(y64), .CO(co64), .OV(ov64), .ZERO(zero64));

   rc_add_sub_serial #(.WIDTH(32), .DIGIT(32)) dut1 (
      .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1), .SnA(sna1),
      .BUSY(busy1), .DONE(done1), .Y(y1), .CO(co1), .OV(ov1), .ZERO(zero1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a, b;
      logic        s;
      logic [31:0] y;
      logic        co, ov, z;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Plain integer arithmetic: unsigned wide result for Y/CO, signed range test for OV.
   function automatic void ref_op(input logic [31:0] x, input logic [31:0] v, input logic s,
                                  output logic [31:0] r, output logic c, output logic o,
                                  output logic z);
      longint sx, sv, sr;
      logic [32:0] w;
      sx = longint'($signed(x));
      sv = longint'($signed(v));
      if (s) begin
         w  = {1'b0, x} - {1'b0, v};
         c  = (x >= v);
         sr = sx - sv;
      end else begin
         w  = {1'b0, x} + {1'b0, v};
         c  = w[32];
         sr = sx + sv;
      end
      r = w[31:0];
      o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      z = (r == 32'd0);
   endfunction

   // Launch one operation; lat = edges from acceptance to DONE (0 on timeout).
   // With disturb set, operands change and START is pulsed while the unit is busy.
   task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                         input bit disturb, output int lat);
      @(negedge clk);
      a = oa; b = ob; sna = os; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge clk);
         #1 start = 1'b0;
         if (done) lat = i;
         else if (disturb && i == 1) begin
            a = $urandom; b = $urandom; sna = ~os; start = 1'b1;
         end
      end
   endtask

   initial begin
      int          lat, seen;
      logic [31:0] ry;
      logic        rc, ro, rz, rs;
      logic [31:0] ra, rb;

      vecs[0] = '{32'd22,         32'd1,  1'b0, 32'd23,         1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'd11,         32'd9,  1'b1, 32'd2,          1'b1, 1'b0, 1'b0};
      vecs[2] = '{32'd9,          32'd11, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0};
      vecs[3] = '{32'hFFFF_FFFF,  32'd1,  1'b0, 32'd0,          1'b1, 1'b0, 1'b1};
      vecs[4] = '{32'd1,          32'd0,  1'b1, 32'd1,          1'b1, 1'b0, 1'b0};
      vecs[5] = '{32'h7FFF_FFFF,  32'd1,  1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0};
      vecs[6] = '{32'h8000_0000,  32'd1,  1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0};
      vecs[7] = '{32'd5,          32'd5,  1'b1, 32'd0,          1'b1, 1'b0, 1'b1};

      rst = 1'b1;
      start = 1'b0; a = '0; b = '0; sna = 1'b0;
      start64 = 1'b0; a64 = '0; b64 = '0; sna64 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; sna1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_y", y, 0);   chk("rst_co", co, 0);     chk("rst_ov", ov, 0);
      chk("rst_zero", zero, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, lat);
         chk($sformatf("vec%0d_lat", i), lat, 4);
         chk($sformatf("vec%0d_y", i), y, vecs[i].y);
         chk($sformatf("vec%0d_co", i), co, vecs[i].co);
         chk($sformatf("vec%0d_ov", i), ov, vecs[i].ov);
         chk($sformatf("vec%0d_zero", i), zero, vecs[i].z);
         @(posedge clk);
         #1 chk($sformatf("vec%0d_done_pulse", i), done, 0);
      end

      // START held high: accepted at edge 1, then every fifth edge thereafter.
      @(negedge clk);
      a = 32'd1000; b = 32'd1; sna = 1'b1; start = 1'b1;
      for (int e = 1; e <= 15; e++) begin
         @(posedge clk);
         #1 chk($sformatf("held_done_e%0d", e), done, (e % 5 == 0));
      end
      start = 1'b0;
      chk("held_y", y, 999);
      @(posedge clk);
      #1 chk("held_idle_done", done, 0);

      // Operands changed and START pulsed mid-run: the latched operation must finish unchanged.
      run_op(32'd100, 32'd50, 1'b0, 1'b1, lat);
      chk("busy_lat", lat, 4);
      chk("busy_y", y, 150);
      repeat (6) @(posedge clk);
      #1;
      chk("busy_y_hold", y, 150);
      chk("busy_no_restart", busy, 0);

      // Reset while digit 2 is pending.
      run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, lat);
      @(negedge clk);
      a = 32'd5; b = 32'd3; sna = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_rst_y", y, 0);   chk("mid_rst_co", co, 0);     chk("mid_rst_ov", ov, 0);
      chk("mid_rst_zero", zero, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 if (done || busy) seen++;
      end
      chk("mid_rst_quiet", seen, 0);
      run_op(32'd5, 32'd3, 1'b0, 1'b0, lat);
      chk("post_rst_lat", lat, 4);
      chk("post_rst_y", y, 8);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = (i % 8 == 0) ? ra : $urandom;
         rs = 1'($urandom_range(0, 1));
         ref_op(ra, rb, rs, ry, rc, ro, rz);
         run_op(ra, rb, rs, (i % 5 == 0), lat);
         chk($sformatf("rnd%0d_lat", i), lat, 4);
         chk($sformatf("rnd%0d_y", i), y, ry);
         chk($sformatf("rnd%0d_co", i), co, rc);
         chk($sformatf("rnd%0d_ov", i), ov, ro);
         chk($sformatf("rnd%0d_zero", i), zero, rz);
      end

      @(negedge clk);
      a64 = 64'hFFFF_FFFF_FFFF_FFFE; b64 = 64'd1; sna64 = 1'b0; start64 = 1'b1;
      @(posedge clk);
      #1 start64 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge clk);
         #1 if (done64) lat = i;
      end
      chk("w64_lat", lat, 4);
      chk("w64_y", y64, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("w64_ov", ov64, 0);
      chk("w64_co", co64, 0);
      chk("w64_zero", zero64, 0);

      @(negedge clk);
      a1 = 32'd22; b1 = 32'd1; sna1 = 1'b0; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge clk);
         #1 if (done1) lat = i;
      end
      chk("n1_lat", lat, 1);
      chk("n1_y", y1, 23);
      @(posedge clk);
      #1 chk("n1_done_pulse", done1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
